// File: rtl/sort_ram_median_if.sv
// Sample-buffer sort bus: stream in, sort control, results, readback.
// master drives in_data/in_valid/clear/start/rd_addr; slave answers.
interface sort_ram_median_if #(
  parameter int DATA_W = 24,
  parameter int ADDR_W = 10
);
  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;
  logic              clear;
  logic              start;
  logic              busy;
  logic              done;
  logic [ADDR_W:0]   count;
  logic [DATA_W-1:0] min_out;
  logic [DATA_W-1:0] med_out;
  logic [DATA_W-1:0] max_out;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;

  modport master (
    output in_data, in_valid, clear,
    output start, rd_addr,
    input  in_ready, busy, done, count,
    input  min_out, med_out, max_out,
    input  rd_data
  );

  modport slave (
    input  in_data, in_valid, clear,
    input  start, rd_addr,
    output in_ready, busy, done, count,
    output min_out, med_out, max_out,
    output rd_data
  );
endinterface

// File: rtl/sort_ram_median.sv
// Sample buffer with in-place bubble sort over one RAM port.
// Ports: clk, rst (sync, high), bus (slave side of sort_ram_median_if).
module sort_ram_median #(
  parameter int DATA_W = 24,
  parameter int DEPTH  = 540,
  parameter int ADDR_W = 10
) (
  input  logic                clk,
  input  logic                rst,
  sort_ram_median_if.slave    bus
);

  typedef enum logic [2:0] {
    IDLE, SORT_RD0, SORT_RD1, SORT_WR0,
    SORT_WR1, PASS_END, FETCH, DONE
  } state_t;

  localparam logic [ADDR_W:0] FULL =
    (ADDR_W+1)'(DEPTH);

  state_t            state;
  logic [ADDR_W:0]   count, n, passes;
  logic [ADDR_W:0]   nm1, n_nx;
  logic [ADDR_W-1:0] i, i_nx, a_c;
  logic [DATA_W-1:0] x, y, sq;
  logic [DATA_W-1:0] tmin, tmed, wdata;
  logic [DATA_W-1:0] rd_q, min_q, med_q, max_q;
  logic [1:0]        fs;
  logic              swapped, busy_q, done_q;
  logic              rdy, acc, we, last;

  logic [DATA_W-1:0] ram [DEPTH];

  assign rdy  = (state == IDLE) && (count < FULL);
  assign acc  = bus.in_valid && rdy && !bus.clear;
  assign n_nx = count + {{ADDR_W{1'b0}}, acc};
  assign nm1  = n - 1'b1;
  assign i_nx = i + 1'b1;
  assign last = ({1'b0, i_nx} == nm1);

  assign bus.in_ready = rdy;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.count    = count;
  assign bus.min_out  = min_q;
  assign bus.med_out  = med_q;
  assign bus.max_out  = max_q;
  assign bus.rd_data  = rd_q;

  // Single port: one address per cycle, shared by
  // append writes, readback and the sort engine.
  always_comb begin
    a_c   = bus.rd_addr;
    we    = 1'b0;
    wdata = x;
    unique case (state)
      IDLE: if (acc) begin
        a_c   = count[ADDR_W-1:0];
        we    = 1'b1;
        wdata = bus.in_data;
      end
      SORT_RD0, SORT_RD1: a_c = i_nx;
      SORT_WR0: begin
        a_c   = i;
        we    = 1'b1;
        wdata = y;
      end
      SORT_WR1: begin
        a_c   = i_nx;
        we    = 1'b1;
        wdata = x;
      end
      PASS_END: a_c = '0;
      FETCH: begin
        unique case (fs)
          2'd0:    a_c = '0;
          2'd1:    a_c = nm1[ADDR_W:1];
          default: a_c = nm1[ADDR_W-1:0];
        endcase
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (we) ram[a_c] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      count   <= '0;
      n       <= '0;
      passes  <= '0;
      i       <= '0;
      x       <= '0;
      y       <= '0;
      sq      <= '0;
      tmin    <= '0;
      tmed    <= '0;
      fs      <= '0;
      swapped <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      min_q   <= '0;
      med_q   <= '0;
      max_q   <= '0;
      rd_q    <= '0;
    end else begin
      // WR1 forwards a[i] as the next a[i+1] so the
      // read-before-write on that address is bypassed.
      if (state != IDLE)
        sq <= (state == SORT_WR1) ? x : ram[a_c];
      unique case (state)
        IDLE: begin
          // Readback pauses on cycles that append.
          if (!acc) rd_q <= ram[a_c];
          if (bus.clear) begin
            count <= '0;
          end else begin
            count <= n_nx;
            if (bus.start && n_nx != '0) begin
              n       <= n_nx;
              passes  <= '0;
              swapped <= 1'b1;
              busy_q  <= 1'b1;
              state   <= PASS_END;
            end
          end
        end
        PASS_END: begin
          if (swapped && passes < nm1) begin
            i       <= '0;
            swapped <= 1'b0;
            state   <= SORT_RD0;
          end else begin
            fs    <= '0;
            state <= FETCH;
          end
        end
        SORT_RD0: begin
          x     <= sq;
          state <= SORT_RD1;
        end
        SORT_RD1: begin
          if (x > sq) begin
            y     <= sq;
            state <= SORT_WR0;
          end else if (last) begin
            passes <= passes + 1'b1;
            state  <= PASS_END;
          end else begin
            i     <= i_nx;
            state <= SORT_RD0;
          end
        end
        SORT_WR0: begin
          swapped <= 1'b1;
          state   <= SORT_WR1;
        end
        SORT_WR1: begin
          if (last) begin
            passes <= passes + 1'b1;
            state  <= PASS_END;
          end else begin
            i     <= i_nx;
            state <= SORT_RD0;
          end
        end
        FETCH: begin
          fs <= fs + 1'b1;
          unique case (fs)
            2'd1: tmin <= sq;
            2'd2: tmed <= sq;
            2'd3: begin
              min_q  <= tmin;
              med_q  <= tmed;
              max_q  <= sq;
              done_q <= 1'b1;
              busy_q <= 1'b0;
              state  <= DONE;
            end
            default: ;
          endcase
        end
        DONE: begin
          done_q <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
